// File: rtl/hazard_stall_ctrl.sv
// Load-use / dcache-busy hazard controller for the ID stage of a 5-stage core.
// Latency: control outputs are combinational (zero-cycle); state and counter update on clk_i rising edge.
// Backpressure: MemStall_i freezes the pipeline; pending bubbles are paused, not dropped, while frozen.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   MemRead_i, RDaddr_i           : ID/EX load and its destination register
//   RS1addr_i/RS2addr_i, RSxuse_i : IF/ID source registers and whether they are read
//   Branch_i                      : taken branch resolved in ID
//   MemStall_i                    : data cache busy
//   PCWrite_o, Stall_o, No_op_o, Flush_o : pipeline control
//   Hazard_cnt_o                  : saturating count of bubble cycles
module hazard_stall_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  input  logic              RS1use_i,
  input  logic              RS2use_i,
  input  logic              Branch_i,
  input  logic              MemStall_i,
  output logic              PCWrite_o,
  output logic              Stall_o,
  output logic              No_op_o,
  output logic              Flush_o,
  output logic [CNT_W-1:0]  Hazard_cnt_o
);

  localparam int REM_W = $clog2(LOAD_LAT + 1);
  localparam logic [REM_W-1:0] LAT_M1  = REM_W'(LOAD_LAT - 1);
  localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_LOAD_STALL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REM_W-1:0]   r_remain;
  logic [REM_W-1:0]   w_remain_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_hz;
  logic               w_bubble;
  logic               w_freeze;

  // x0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign w_hz = MemRead_i && (RDaddr_i != '0) &&
                ((RS1use_i && (RS1addr_i == RDaddr_i)) ||
                 (RS2use_i && (RS2addr_i == RDaddr_i)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_bubble     = 1'b0;
    w_freeze     = 1'b0;
    PCWrite_o    = 1'b0;
    Stall_o      = 1'b0;
    No_op_o      = 1'b0;
    Flush_o      = 1'b0;

    // A busy cache outranks everything; a hazard seen while frozen is
    // simply re-detected once the freeze lifts because ID/EX is held too.
    if (MemStall_i) begin
      w_freeze = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hz) begin
            w_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt  = ST_LOAD_STALL;
              w_remain_nxt = LAT_M1;
            end
          end
        end
        ST_LOAD_STALL: begin
          w_bubble     = 1'b1;
          w_remain_nxt = r_remain - REM_ONE;
          if (r_remain == REM_ONE) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Outputs are all forced low while reset is asserted, independent of state.
    // A taken branch only flushes in RUN; otherwise it stays in ID and re-resolves.
    if (rst_i) begin
      if (w_freeze) begin
        Stall_o = 1'b1;
      end else if (w_bubble) begin
        Stall_o = 1'b1;
        No_op_o = 1'b1;
      end else begin
        PCWrite_o = 1'b1;
        Flush_o   = Branch_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (No_op_o && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign Hazard_cnt_o = r_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read;
  logic [4:0] rd, rs1, rs2;
  logic       use1, use2, branch, mstall;

  logic [2:0]  pcw, stl, nop, fl;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;

  // Reference state: bubbles still owed and bubble count, per DUT.
  int m_pend [3];
  int m_cnt  [3];
  int lat    [3] = '{1, 3, 3};
  int cmax   [3] = '{65535, 65535, 3};

  always #5 clk = ~clk;

  // dut0: LOAD_LAT=1, dut1: LOAD_LAT=3, dut2: LOAD_LAT=3 with a 2-bit counter.
  hazard_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(mem_read), .RDaddr_i(rd),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RS1use_i(use1), .RS2use_i(use2),
    .Branch_i(branch), .MemStall_i(mstall),
    .PCWrite_o(pcw[0]), .Stall_o(stl[0]), .No_op_o(nop[0]), .Flush_o(fl[0]),
    .Hazard_cnt_o(cnt0));

  hazard_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(mem_read), .RDaddr_i(rd),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RS1use_i(use1), .RS2use_i(use2),
    .Branch_i(branch), .MemStall_i(mstall),
    .PCWrite_o(pcw[1]), .Stall_o(stl[1]), .No_op_o(nop[1]), .Flush_o(fl[1]),
    .Hazard_cnt_o(cnt1));

  hazard_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(mem_read), .RDaddr_i(rd),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RS1use_i(use1), .RS2use_i(use2),
    .Branch_i(branch), .MemStall_i(mstall),
    .PCWrite_o(pcw[2]), .Stall_o(stl[2]), .No_op_o(nop[2]), .Flush_o(fl[2]),
    .Hazard_cnt_o(cnt2));

  function automatic logic [3:0] act_out(int i);
    return {pcw[i], stl[i], nop[i], fl[i]};
  endfunction

  function automatic int act_cnt(int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic bit m_hz();
    return mem_read && (rd != 0) &&
           ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

  // Expected {PCWrite, Stall, No_op, Flush} from the current inputs and model state.
  function automatic logic [3:0] exp_out(int i);
    if (!rst_n)                   return 4'b0000;
    if (mstall)                   return 4'b0100;
    if (m_pend[i] > 0 || m_hz())  return 4'b0110;
    return {1'b1, 1'b0, 1'b0, branch};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0;
      m_cnt[i]  = 0;
    end
  endfunction

  task automatic set_idle_inputs();
    mem_read = 0; rd = 0; rs1 = 0; rs2 = 0;
    use1 = 0; use2 = 0; branch = 0; mstall = 0;
  endtask

  task automatic set_hazard();
    mem_read = 1; rd = 5'd5; rs1 = 5'd5; use1 = 1; rs2 = 5'd9; use2 = 0;
  endtask

  // Advance one clock edge, updating the model with what happens on it.
  task automatic step();
    bit bub [3];
    for (int i = 0; i < 3; i++)
      bub[i] = rst_n && !mstall && (m_pend[i] > 0 || m_hz());
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (bub[i]) begin
        if (m_pend[i] > 0) m_pend[i]--;
        else               m_pend[i] = lat[i] - 1;
        if (m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    set_idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    set_hazard();
    branch = 1;
    #3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_out(i) !== 4'b0000) begin
        failures++;
        $display("FAIL reset_outs dut%0d actual=%b required=0000", i, act_out(i));
      end
      checks++;
      if (act_cnt(i) != 0) begin
        failures++;
        $display("FAIL reset_cnt dut%0d actual=%0d required=0", i, act_cnt(i));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    set_idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Single hazard; LOAD_LAT=1 gives one bubble, LOAD_LAT=3 gives three.
  task automatic test_load_use();
    logic [3:0] exp1 [5] = '{4'b0110, 4'b0110, 4'b0110, 4'b1000, 4'b1000};
    do_reset();
    set_hazard();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (act_out(1) !== exp1[c]) begin
        failures++;
        $display("FAIL lat3_cycle%0d actual=%b required=%b", c, act_out(1), exp1[c]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_out(i) !== exp_out(i)) begin
          failures++;
          $display("FAIL load_use_outs dut%0d cyc%0d actual=%b required=%b", i, c, act_out(i), exp_out(i));
        end
      end
      step();
      if (c == 0) mem_read = 0;
    end
    checks++;
    if (act_cnt(0) != 1) begin
      failures++;
      $display("FAIL lat1_cnt actual=%0d required=1", act_cnt(0));
    end
    checks++;
    if (act_cnt(1) != 3) begin
      failures++;
      $display("FAIL lat3_cnt actual=%0d required=3", act_cnt(1));
    end
  endtask

  task automatic test_x0_and_unused();
    do_reset();
    mem_read = 1; rd = 0; rs1 = 0; use1 = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_out(i) !== 4'b1000) begin
        failures++;
        $display("FAIL x0_run dut%0d actual=%b required=1000", i, act_out(i));
      end
    end
    step();
    rd = 5'd7; rs2 = 5'd7; use2 = 0; rs1 = 5'd3; use1 = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_out(i) !== 4'b1000) begin
        failures++;
        $display("FAIL rs2_unused_run dut%0d actual=%b required=1000", i, act_out(i));
      end
    end
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_cnt(i) != 0) begin
        failures++;
        $display("FAIL x0_cnt dut%0d actual=%0d required=0", i, act_cnt(i));
      end
    end
  endtask

  // Freeze after the first bubble; the remaining two bubbles follow afterwards.
  task automatic test_memstall();
    logic [3:0] exp1 [6] = '{4'b0110, 4'b0100, 4'b0100, 4'b0110, 4'b0110, 4'b1000};
    do_reset();
    set_hazard();
    for (int c = 0; c < 6; c++) begin
      mstall = (c == 1 || c == 2);
      #1;
      checks++;
      if (act_out(1) !== exp1[c]) begin
        failures++;
        $display("FAIL memstall_cycle%0d actual=%b required=%b", c, act_out(1), exp1[c]);
      end
      step();
      if (c == 0) mem_read = 0;
    end
    checks++;
    if (act_cnt(1) != 3) begin
      failures++;
      $display("FAIL memstall_cnt actual=%0d required=3", act_cnt(1));
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_hazard();
    branch = 1;
    #1;
    checks++;
    if (act_out(0) !== 4'b0110) begin
      failures++;
      $display("FAIL branch_with_hz actual=%b required=0110", act_out(0));
    end
    step();
    set_idle_inputs();
    branch = 1;
    mstall = 1;
    #1;
    checks++;
    if (act_out(0) !== 4'b0100) begin
      failures++;
      $display("FAIL branch_with_freeze actual=%b required=0100", act_out(0));
    end
    mstall = 0;
    #1;
    checks++;
    if (act_out(0) !== 4'b1001) begin
      failures++;
      $display("FAIL branch_run actual=%b required=1001", act_out(0));
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_hazard();
    step();
    mem_read = 0;
    branch = 1;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_out(i) !== 4'b0000 || act_cnt(i) != 0) begin
        failures++;
        $display("FAIL reset_mid dut%0d actual=%b/%0d required=0000/0", i, act_out(i), act_cnt(i));
      end
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_out(i) !== 4'b1001) begin
        failures++;
        $display("FAIL reset_release_run dut%0d actual=%b required=1001", i, act_out(i));
      end
    end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    set_hazard();
    repeat (5) step();
    checks++;
    if (act_cnt(2) != 3) begin
      failures++;
      $display("FAIL cnt_saturate actual=%0d required=3", act_cnt(2));
    end
    checks++;
    if (act_cnt(0) != 5) begin
      failures++;
      $display("FAIL cnt_lat1_5 actual=%0d required=5", act_cnt(0));
    end
    set_idle_inputs();
    repeat (3) step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      mem_read = ($urandom_range(0, 2) != 0);
      rd       = 5'($urandom_range(0, 3));
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      use1     = $urandom_range(0, 1) == 1;
      use2     = $urandom_range(0, 1) == 1;
      branch   = $urandom_range(0, 1) == 1;
      mstall   = ($urandom_range(0, 4) == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_out(i) !== exp_out(i)) begin
          failures++;
          $display("FAIL rand_outs dut%0d cyc%0d actual=%b required=%b", i, c, act_out(i), exp_out(i));
        end
      end
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_cnt(i) != m_cnt[i]) begin
          failures++;
          $display("FAIL rand_cnt dut%0d cyc%0d actual=%0d required=%0d", i, c, act_cnt(i), m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    set_idle_inputs();
    rst_n = 0;
    model_reset();
    test_reset();
    test_load_use();
    test_x0_and_unused();
    test_memstall();
    test_branch();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
